// File: rtl/result_collector.sv
// Round-robin result collector: merges NUM_WRK worker result streams into one
// registered valid/ready output. Optional delivered-result counter: RESULT_COLLECTOR_CNT_EN.
module result_collector #(
    parameter  int unsigned NUM_WRK = 4,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned SRC_W   = $clog2(NUM_WRK)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_WRK-1:0]        wrk_valid,
    input  logic [NUM_WRK*DATA_W-1:0] wrk_data,
    output logic [NUM_WRK-1:0]        wrk_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
`ifdef RESULT_COLLECTOR_CNT_EN
    ,
    output logic [31:0]               out_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_WRK-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SRC_W-1:0]    src_q, src_d;

    logic [SRC_W-1:0]    ptr_idx;
    logic [SRC_W-1:0]    cand_idx;
    logic [SRC_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [NUM_WRK-1:0]  gnt_oh;
    logic [NUM_WRK-1:0]  gnt_rot;
    logic [DATA_W-1:0]   gnt_data;
    logic                can_load;
    logic                load;
    logic                drain;

    // Rotating-priority search starting at the pointer, wrapping past NUM_WRK-1.
    always_comb begin
        ptr_idx  = '0;
        cand_idx = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        for (int unsigned i = 0; i < NUM_WRK; i++) begin
            if (ptr_q[i]) begin
                ptr_idx = SRC_W'(i);
            end
        end
        for (int unsigned k = 0; k < NUM_WRK; k++) begin
            cand_idx = SRC_W'((32'(ptr_idx) + k) % NUM_WRK);
            if (!gnt_any && wrk_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // One-hot grant, the pointer value that follows it, and the granted payload.
    always_comb begin
        gnt_oh   = '0;
        gnt_data = '0;
        gnt_oh[gnt_idx] = gnt_any;
        gnt_rot  = {gnt_oh[NUM_WRK-2:0], gnt_oh[NUM_WRK-1]};
        for (int unsigned i = 0; i < NUM_WRK; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                gnt_data = wrk_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign can_load = (state_q == EMPTY) || out_ready;
    assign load     = gnt_any && can_load;
    assign drain    = (state_q == FULL) && out_ready;

    // Output-stage FSM: next state, payload capture and worker accept.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        src_d     = src_q;
        wrk_ready = '0;

        if (can_load) begin
            wrk_ready = gnt_oh;
        end

        if (load) begin
            data_d = gnt_data;
            src_d  = gnt_idx;
            ptr_d  = gnt_rot;
        end

        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (drain && !load) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= EMPTY;
            ptr_q   <= NUM_WRK'(1);
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

`ifdef RESULT_COLLECTOR_CNT_EN
    logic [31:0] cnt_q;

    // Counts downstream transfers; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (NUM_WRK=4, DATA_W=16) with hand-computed expectations.
module tb_result_collector;

    localparam int unsigned NUM_WRK = 4;
    localparam int unsigned DATA_W  = 16;

    logic                      clk;
    logic                      n_rst;
    logic [NUM_WRK-1:0]        wrk_valid;
    logic [NUM_WRK*DATA_W-1:0] wrk_data;
    logic [NUM_WRK-1:0]        wrk_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_src;
    logic                      out_ready;
`ifdef RESULT_COLLECTOR_CNT_EN
    logic [31:0]               out_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    result_collector #(
        .NUM_WRK(NUM_WRK),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .wrk_valid(wrk_valid),
        .wrk_data (wrk_data),
        .wrk_ready(wrk_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
`ifdef RESULT_COLLECTOR_CNT_EN
        ,
        .out_count(out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        wrk_data = {d3, d2, d1, d0};
    endtask

    initial begin
        n_rst     = 1'b0;
        wrk_valid = '0;
        out_ready = 1'b0;
        set_data(16'h0, 16'h0, 16'h0, 16'h0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_wrk_ready", 32'(wrk_ready), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Single request from worker 0
        wrk_valid = 4'b0001;
        set_data(16'h0012, 16'h0, 16'h0, 16'h0);
        out_ready = 1'b1;
        #1;
        check("t1_ready", 32'(wrk_ready), 32'b0001);
        tick();
        wrk_valid = 4'b0000;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(out_data),  32'h0012);
        check("t1_src",   32'(out_src),   32'd0);
        wrk_valid = 4'b1111;
        #1;
        check("t1_ptr_w1", 32'(wrk_ready), 32'b0010);
        wrk_valid = 4'b0000;

        // Fairness: all valid after reset gives 0,1,2,3,0,1
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
        set_data(16'h0010, 16'h0011, 16'h0012, 16'h0013);
        wrk_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_src",   32'(out_src),   32'(i % 4));
            check("rr_data",  32'(out_data),  32'(16'h0010 + 16'(i % 4)));
        end

        // Stall with all workers valid
        out_ready = 1'b0;
        #1;
        check("stall_ready0", 32'(wrk_ready), 32'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ready", 32'(wrk_ready), 32'b0000);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_src",   32'(out_src),   32'd1);
            check("stall_data",  32'(out_data),  32'h0011);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(wrk_ready), 32'b0100);
        tick();
        check("release_src",  32'(out_src),  32'd2);
        check("release_data", 32'(out_data), 32'h0012);

        // Pointer at worker 3, only worker 1 valid: wrap search
        wrk_valid = 4'b0010;
        set_data(16'h0010, 16'h0ABC, 16'h0012, 16'h0013);
        #1;
        check("wrap_ready", 32'(wrk_ready), 32'b0010);
        tick();
        check("wrap_src",  32'(out_src),  32'd1);
        check("wrap_data", 32'(out_data), 32'h0ABC);
        wrk_valid = 4'b1111;
        #1;
        check("wrap_ptr_w2", 32'(wrk_ready), 32'b0100);

        // Drain with no request, then idle must not rotate the pointer
        wrk_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  32'(out_data),  32'h0ABC);
        check("drain_src",   32'(out_src),   32'd1);
        tick();
        wrk_valid = 4'b1111;
        #1;
        check("idle_ptr_w2", 32'(wrk_ready), 32'b0100);

        // Load, stall, then reset mid-operation
        tick();
        check("pre_rst_src", 32'(out_src), 32'd2);
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_src",   32'(out_src),   32'd0);
        check("mid_rst_ready", 32'(wrk_ready), 32'b0001);
        n_rst = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_src",   32'(out_src),   32'd0);
        check("post_rst_data",  32'(out_data),  32'h0010);

`ifdef RESULT_COLLECTOR_CNT_EN
        // Counter: 10 deliveries, 3 stalled cycles, then forced wrap
        n_rst = 1'b0;
        #1;
        check("cnt_rst", out_count, 32'd0);
        n_rst = 1'b1;
        out_ready = 1'b1;
        wrk_valid = 4'b1111;
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        check("cnt_10", out_count, 32'd10);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt_stall", out_count, 32'd10);
        end
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        out_ready = 1'b1;
        tick();
        check("cnt_wrap", out_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_collector.md
# result_collector

Round-robin result collector for the Julia worker array: gathers finished results from NUM_WRK workers and serialises them onto one downstream valid/ready stream toward the frame writer. It is the return-path counterpart of the round-robin dispatch mask: dispatch hands work out in rotation, and this block takes results back in rotation. Fairness comes from a rotating one-hot priority pointer, and the output is a registered single-entry stage with full-throughput pass-through.

## Interface
- NUM_WRK, 4, number of Julia workers; legal range 2–16.
- DATA_W, 16, result width in bits (iteration count).
- SRC_W, $clog2(NUM_WRK), width of the source index; derived, never overridden.

- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- wrk_valid  in  NUM_WRK  per-worker result valid.
- wrk_data  in  NUM_WRK*DATA_W  flattened results; worker i occupies bits [i*DATA_W +: DATA_W].
- wrk_ready  out  NUM_WRK  per-worker accept, one-hot or zero.
- out_valid  out  1  downstream result valid.
- out_data  out  DATA_W  downstream result.
- out_src  out  SRC_W  index of the worker that produced out_data.
- out_ready  in  1  downstream accept.
- out_count  out  32  delivered-result count; present only with RESULT_COLLECTOR_CNT_EN.

## Operation
- Priority pointer `ptr`: one-hot, NUM_WRK bits. Reset value is 1, so worker 0 has highest priority.
- Grant search order: from the bit set in ptr, upward, wrapping from NUM_WRK-1 to 0. The first worker with wrk_valid set wins.
- `can_load` = !out_valid || out_ready.
- wrk_ready = grant when can_load, else 0. wrk_ready is combinational from wrk_valid, ptr, out_valid and out_ready.
- Worker transfer: wrk_valid[i] && wrk_ready[i].
- On a worker transfer from worker g:
  - out_data ← wrk_data slice g.
  - out_src ← g.
  - out_valid ← 1.
  - ptr ← one-hot at (g+1) mod NUM_WRK.
- Downstream transfer: out_valid && out_ready.
  - If no worker transfer happens in the same cycle, out_valid ← 0. out_data and out_src hold.
  - If a worker transfer happens in the same cycle (simultaneous drain and load), the new result replaces the old one and out_valid stays 1.
- Stall: when out_valid && !out_ready, all wrk_ready are 0. out_data, out_src and ptr hold stable.
- ptr never moves without a grant, and idle cycles do not rotate it.
- States:
  - EMPTY (out_valid=0): any valid request loads the output.
  - FULL (out_valid=1): stay FULL on stall or on drain+load; go to EMPTY on drain with no request.
- A worker must hold wrk_valid and its wrk_data until it sees wrk_ready. The block does not register worker inputs.

## Timing
- Reset values (asynchronous, immediate):
  - out_valid=0, out_data=0, out_src=0, ptr=1, out_count=0.
  - wrk_ready evaluates to the grant, which is valid because out_valid=0.
- Latency: a worker transfer at edge N gives out_valid=1 with the data after edge N, i.e. one cycle.
- Throughput: one result per cycle while out_ready is held high and any worker is valid.
- Fairness: with all workers continuously valid, grants follow 0,1,…,NUM_WRK-1,0,… exactly.
- A worker is served at most NUM_WRK-1 granted transfers after raising valid.
- Reset mid-operation: a pending output is discarded and ptr returns to 1. Workers whose valid was not accepted keep their data and retry.

## Configuration
- RESULT_COLLECTOR_CNT_EN defined:
  - out_count port exists, a 32-bit counter.
  - It increments on every downstream transfer, wraps 0xFFFFFFFF→0, and resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then wrk_valid=0001 with worker 0 data 0x0012, out_ready=1:
  - wrk_ready=0001 in the same cycle.
  - Next cycle out_valid=1, out_data=0x0012, out_src=0, and ptr points at worker 1.
- All four workers valid continuously with data 0x10+i, out_ready=1:
  - out_src sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Output loaded, out_ready=0 for 5 cycles with wrk_valid=1111:
  - wrk_ready=0000 throughout; out_data and out_src stable.
  - On releasing out_ready, the next grant is (previous src+1) mod 4.
- ptr at worker 3 with only worker 1 valid:
  - Worker 1 is granted (wrap search 3→0→1) and ptr moves to worker 2.
- Assert n_rst low while out_valid=1 and out_ready=0:
  - Outputs clear immediately; after release the first grant goes to worker 0 when all are valid.
- With RESULT_COLLECTOR_CNT_EN, 10 results delivered, then 3 stalled cycles:
  - out_count=10, unchanged during the stall.
  - With a counter value forced to 0xFFFFFFFF, one more delivery wraps it to 0.
